// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter: round-robin sharing of one register-file read mux among NUM_REQ requesters,
// with a registered response that forwards same-edge writebacks, including while it is stalled.
module rf_read_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [5*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [4:0]           rf_sel,
  input  logic [31:0]          rf_data,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [4:0]           rsp_addr,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] ptr_next;
  logic           found;
  logic           grant;
  logic           slot_free;
  logic [31:0]    cap_data;
  logic           hold_fwd;
  logic [4:0]     addr_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_a[g] = req_addr[5*g +: 5];
  end

  assign slot_free = !rsp_valid || rsp_ready;

  // Scan from ptr upward, wrapping at NUM_REQ so ids >= NUM_REQ never appear.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign grant     = found && slot_free && rst_n;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
  assign rf_sel    = grant ? addr_a[gnt_id] : 5'd0;
  assign ptr_next  = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

  // The mux still shows the pre-write value on a write edge, so the writeback wins over rf_data.
  assign cap_data = (ZERO_R0 && rf_sel == 5'd0) ? 32'h0 :
                    (wr_en && wr_addr == rf_sel) ? wr_data : rf_data;
  assign hold_fwd = wr_en && wr_addr == rsp_addr && !(ZERO_R0 && rsp_addr == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else if (grant) begin
      ptr       <= ptr_next;
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_addr  <= rf_sel;
      rsp_data  <= cap_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else if (rsp_valid && hold_fwd) begin
      rsp_data  <= wr_data;
    end
  end
endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// tb_rf_read_port_arbiter: directed checks of arbitration order, forwarding, backpressure and reset.
module tb_rf_read_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  rf_sel;
  logic [31:0] rf_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  rf_read_port_arbiter #(.NUM_REQ(4), .IDW(2), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rf_sel(rf_sel), .rf_data(rf_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  assign rf_data = rf[rf_sel];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_addr"}, 32'(rsp_addr), 32'(a));
    chk({tag, "_data"}, rsp_data, d);
  endtask

  initial begin
    logic [1:0] e;
    logic       got;
    for (int k = 0; k < 32; k++) rf[k] = 32'h1000 + k;
    rst_n = 1'b0; req_valid = 4'hF; req_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsp_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_addr", 32'(rsp_addr), 32'h0);
    chk("rst_data", rsp_data, 32'h0);
    step();
    rst_n = 1'b1;
    // T1: req0 wins first after reset
    req_valid = 4'b0011; req_addr = {5'd0, 5'd0, 5'd4, 5'd3};
    #1;
    chk("t1_ready0", 32'(req_ready), 32'b0001);
    chk("t1_sel0", 32'(rf_sel), 32'd3);
    step();
    chk_rsp("t1_rsp0", 2'd0, 5'd3, 32'h1003);
    chk("t1_ready1", 32'(req_ready), 32'b0010);
    step();
    chk_rsp("t1_rsp1", 2'd1, 5'd4, 32'h1004);
    // T2: round robin continues from ptr=2
    req_valid = 4'hF; req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    for (int c = 0; c < 8; c++) begin
      e = 2'(c + 2);
      #1;
      chk("t2_ready", 32'(req_ready), 32'(4'b0001 << e));
      step();
      chk_rsp("t2_rsp", e, 5'(10 + e), 32'h1000 + 32'(10 + e));
    end
    // T3: forwarding from writeback, and r0 forced to zero
    req_valid = 4'b0001; req_addr = {15'd0, 5'd7};
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    #1;
    chk("t3_ready", 32'(req_ready), 32'b0001);
    step();
    chk_rsp("t3_fwd", 2'd0, 5'd7, 32'hDEADBEEF);
    req_addr = {15'd0, 5'd0}; wr_addr = 5'd0; wr_data = 32'h12345678;
    step();
    chk_rsp("t3_r0", 2'd0, 5'd0, 32'h0);
    wr_en = 1'b0;
    // T4: backpressure with forwarding into the held response
    req_addr = {15'd0, 5'd9};
    step();
    chk_rsp("t4_load", 2'd0, 5'd9, 32'h1009);
    rsp_ready = 1'b0; req_valid = 4'hF; req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    #1;
    chk("t4_ready_a", 32'(req_ready), 32'h0);
    step();
    chk_rsp("t4_hold_a", 2'd0, 5'd9, 32'h1009);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    #1;
    chk("t4_ready_b", 32'(req_ready), 32'h0);
    step();
    chk_rsp("t4_hold_b", 2'd0, 5'd9, 32'hA5A5A5A5);
    wr_en = 1'b0;
    #1;
    chk("t4_ready_c", 32'(req_ready), 32'h0);
    step();
    chk_rsp("t4_hold_c", 2'd0, 5'd9, 32'hA5A5A5A5);
    // T5: drain and refill in the same cycle, no bubble
    rsp_ready = 1'b1;
    #1;
    chk("t5_ready", 32'(req_ready), 32'b0010);
    step();
    chk_rsp("t5_rsp1", 2'd1, 5'd11, 32'h100B);
    step();
    chk_rsp("t5_rsp2", 2'd2, 5'd12, 32'h100C);
    // T6: req2 served despite req0 toggling (ptr=3 here)
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      req_valid = {1'b0, 1'b1, 1'b0, 1'(c % 2 == 0)};
      #1;
      if (c == 0) chk("t6_first", 32'(req_ready), 32'b0001);
      got = req_ready[2];
      if (!got) step();
    end
    chk("t6_fair", 32'(got), 32'd1);
    step();
    chk_rsp("t6_rsp", 2'd2, 5'd12, 32'h100C);
    // Mid-stream reset drops the pending response
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h0);
    chk("mr_data", rsp_data, 32'h0);
    step();
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0011; req_addr = {5'd0, 5'd0, 5'd4, 5'd3};
    #1;
    chk("mr_ready0", 32'(req_ready), 32'b0001);
    step();
    chk_rsp("mr_rsp0", 2'd0, 5'd3, 32'h1003);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
